alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 8..64.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; forces reset state immediately, released synchronously.
REQ-004 Port: start  input  1  request; sampled only when busy=0.
REQ-005 Port: data1, data2  input  WIDTH each  operands; unsigned.
REQ-006 Port: operation  input  6  op select (codes per REQ-012).
REQ-007 Port: ALUOp  input  2  mode: 01 pass data2, 11 data2*4, 10 BNE compare, 00 normal/BEQ compare.
REQ-008 Port: busy  output  1  high whenever state is not IDLE.
REQ-009 Port: done  output  1  one-cycle pulse; aluResult/zero/divByZero valid and updated in this cycle.
REQ-010 Port: aluResult  output  WIDTH  registered result; holds until next done.
REQ-011 Port: zero, divByZero  output  1 each  registered flags; update only with done.

Function
REQ-012 Op codes (ALUOp 00/10): 00 pass data1, 01 add, 02 sub, 03 and, 04 or, 05 xor, 06 not data1, 07 shl, 08 shr, 09 mul, 0A div, 0B mod; any other code yields aluResult 0.
REQ-013 ALUOp 01 and 11 override operation and are single-cycle.
REQ-014 States: IDLE, EXEC_MUL, EXEC_DIV, DONE; reset state IDLE.
REQ-015 IDLE with start=1: capture data1, data2, operation, ALUOp into internal registers; go to EXEC_MUL (op 09), EXEC_DIV (0A/0B), else DONE.
REQ-016 Single-cycle ops: request accepted at edge k -> done=1 in the cycle after edge k (latency 1).
REQ-017 EXEC_MUL: shift-add, one operand bit per cycle, exactly WIDTH cycles, then DONE; done latency WIDTH+1.
REQ-018 EXEC_DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles, then DONE; done latency WIDTH+1.
REQ-019 DONE lasts one cycle, then IDLE unconditionally; start ignored in DONE and EXEC_* (no queuing).
REQ-020 Arithmetic modulo 2^WIDTH: add/sub wrap; mul returns low WIDTH bits of product.
REQ-021 Shifts: logical; shift amount = data2; amount >= WIDTH yields 0.
REQ-022 Divide by zero (data2=0, op 0A/0B): still WIDTH cycles; div result all ones, mod result = data1; divByZero=1; otherwise divByZero=0 at done.
REQ-023 zero computed on captured operands: ALUOp 10 -> 1 iff data1!=data2; else 1 iff data1==data2.
REQ-024 Operand inputs changing after acceptance shall not affect the in-flight result.

Reset
REQ-025 Reset asserted: state IDLE, busy 0, done 0, aluResult 0, zero 0, divByZero 0, iteration counter 0.
REQ-026 Reset mid-operation aborts it; no done pulse is generated for the aborted request.
REQ-027 First start accepted on the first rising edge after reset deasserts.

Verification
REQ-028 WIDTH=32, ALUOp 00, op 01, 0xFFFFFFFF+1, start 1 cycle -> done next cycle, aluResult 0, zero 0.
REQ-029 op 09, 0x00010000*0x00010001 -> busy 32 cycles, done at cycle 33, aluResult 0x00010000.
REQ-030 op 0A 100/7 -> aluResult 14 after 33 cycles; op 0B 100/7 -> 2; op 0A 5/0 -> 0xFFFFFFFF, divByZero 1.
REQ-031 op 07 data1=1 data2=32 -> aluResult 0; ALUOp 11 data2=5 -> 20; ALUOp 10 data1=data2=9 -> zero 0.
REQ-032 Start re-asserted while busy during mul -> ignored, single done pulse, result unaffected by operand changes.
REQ-033 Reset asserted at cycle 10 of a divide -> outputs zero immediately, no done; new add after release completes in 1 cycle.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add multiply and
// restoring divide, each iterating one bit per cycle.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [5:0]       operation,
  input  logic [1:0]       ALUOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero,
  output logic             divByZero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [5:0] OP_PASS = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_NOT  = 6'h06;
  localparam logic [5:0] OP_SHL  = 6'h07;
  localparam logic [5:0] OP_SHR  = 6'h08;
  localparam logic [5:0] OP_MUL  = 6'h09;
  localparam logic [5:0] OP_DIV  = 6'h0A;
  localparam logic [5:0] OP_MOD  = 6'h0B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC_MUL,
    S_EXEC_DIV,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;      // mul: partial product, div: remainder
  logic [WIDTH-1:0] a_q;        // mul: multiplicand, div: dividend/quotient
  logic [WIDTH-1:0] b_q;        // mul: multiplier, div: divisor
  logic             is_mod_q;
  logic             zero_pend_q;
  logic             dbz_pend_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             dbz_q;

  logic [WIDTH-1:0] simple_res_c;
  logic             zero_c;
  logic             is_mul_c;
  logic             is_div_c;
  logic             shamt_big_c;
  logic [WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH:0]   rem_sub_c;
  logic             div_ge_c;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quot_d;
  logic             last_iter_c;

  assign busy      = busy_q;
  assign done      = done_q;
  assign aluResult = result_q;
  assign zero      = zero_q;
  assign divByZero = dbz_q;

  // Decode of the request presented on the inputs while idle
  always_comb begin
    simple_res_c = '0;
    shamt_big_c  = (data2 >= WIDTH'(WIDTH));
    zero_c       = (ALUOp == 2'b10) ? (data1 != data2) : (data1 == data2);
    is_mul_c     = !ALUOp[0] && (operation == OP_MUL);
    is_div_c     = !ALUOp[0] && ((operation == OP_DIV) || (operation == OP_MOD));
    case (ALUOp)
      2'b01:   simple_res_c = data2;
      2'b11:   simple_res_c = data2 << 2;
      default: begin
        case (operation)
          OP_PASS: simple_res_c = data1;
          OP_ADD:  simple_res_c = data1 + data2;
          OP_SUB:  simple_res_c = data1 - data2;
          OP_AND:  simple_res_c = data1 & data2;
          OP_OR:   simple_res_c = data1 | data2;
          OP_XOR:  simple_res_c = data1 ^ data2;
          OP_NOT:  simple_res_c = ~data1;
          OP_SHL:  simple_res_c = shamt_big_c ? '0 : (data1 << data2);
          OP_SHR:  simple_res_c = shamt_big_c ? '0 : (data1 >> data2);
          default: simple_res_c = '0;
        endcase
      end
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_acc_d   = b_q[0] ? (acc_q + a_q) : acc_q;
    rem_sh_c    = {acc_q, a_q[WIDTH-1]};
    rem_sub_c   = rem_sh_c - {1'b0, b_q};
    div_ge_c    = (rem_sh_c >= {1'b0, b_q});
    rem_d       = div_ge_c ? rem_sub_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
    quot_d      = {a_q[WIDTH-2:0], div_ge_c};
    last_iter_c = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      is_mod_q    <= 1'b0;
      zero_pend_q <= 1'b0;
      dbz_pend_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            acc_q       <= '0;
            a_q         <= data1;
            b_q         <= data2;
            zero_pend_q <= zero_c;
            is_mod_q    <= (operation == OP_MOD);
            dbz_pend_q  <= is_div_c && (data2 == '0);
            if (is_mul_c) begin
              state_q <= S_EXEC_MUL;
            end else if (is_div_c) begin
              state_q <= S_EXEC_DIV;
            end else begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= simple_res_c;
              zero_q   <= zero_c;
              dbz_q    <= 1'b0;
            end
          end
        end
        S_EXEC_MUL: begin
          acc_q <= mul_acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter_c) begin
            state_q  <= S_DONE;
            cnt_q    <= '0;
            done_q   <= 1'b1;
            result_q <= mul_acc_d;
            zero_q   <= zero_pend_q;
            dbz_q    <= 1'b0;
          end
        end
        S_EXEC_DIV: begin
          acc_q <= rem_d;
          a_q   <= quot_d;
          cnt_q <= cnt_q + CW'(1);
          // A zero divisor always "fits": quotient all ones, remainder = dividend
          if (last_iter_c) begin
            state_q  <= S_DONE;
            cnt_q    <= '0;
            done_q   <= 1'b1;
            result_q <= is_mod_q ? rem_d : quot_d;
            zero_q   <= zero_pend_q;
            dbz_q    <= dbz_pend_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32.
module tb_alu_multicycle;

  localparam int unsigned WIDTH = 32;

  logic             clock;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [5:0]       operation;
  logic [1:0]       ALUOp;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] aluResult;
  logic             zero;
  logic             divByZero;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .data1     (data1),
    .data2     (data2),
    .operation (operation),
    .ALUOp     (ALUOp),
    .busy      (busy),
    .done      (done),
    .aluResult (aluResult),
    .zero      (zero),
    .divByZero (divByZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge and follow it to its done pulse
  task automatic run_op(input string tag, input logic [1:0] aop, input logic [5:0] op,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] er, input logic ez, input logic edbz,
                        input int elat, input bit perturb);
    int  n;
    bit  seen;
    bit  busy_ok;
    ALUOp     = aop;
    operation = op;
    data1     = d1;
    data2     = d2;
    start     = 1'b1;
    @(posedge clock);
    n       = 0;
    seen    = 0;
    busy_ok = 1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      n++;
      if (done) begin
        seen = 1;
      end else begin
        if (!busy) busy_ok = 0;
        if (perturb) begin
          start     = 1'b1;
          data1     = $urandom;
          data2     = $urandom;
          operation = 6'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check({tag, "_seen"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(n), 64'(elat));
    check({tag, "_busyrun"}, 64'(busy_ok), 64'd1);
    check({tag, "_res"}, 64'(aluResult), 64'(er));
    check({tag, "_zero"}, 64'(zero), 64'(ez));
    check({tag, "_dbz"}, 64'(divByZero), 64'(edbz));
    check({tag, "_busydone"}, 64'(busy), 64'd1);
    @(negedge clock);
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_hold"}, 64'(aluResult), 64'(er));
  endtask

  initial begin
    int dones;
    reset     = 1'b1;
    start     = 1'b0;
    data1     = '0;
    data2     = '0;
    operation = '0;
    ALUOp     = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_res", 64'(aluResult), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_dbz", 64'(divByZero), 64'd0);
    reset = 1'b0;

    //     tag       ALUOp  op     data1         data2         result        z  dbz lat perturb
    run_op("add_wrap", 2'b00, 6'h01, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 1,  0);
    run_op("mul_a",    2'b00, 6'h09, 32'h00010000, 32'h00010001, 32'h00010000, 0, 0, 33, 0);
    run_op("div_0",    2'b00, 6'h0A, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 1, 33, 0);
    run_op("div_a",    2'b00, 6'h0A, 32'd100,      32'd7,        32'd14,       0, 0, 33, 0);
    run_op("mod_0",    2'b00, 6'h0B, 32'd5,        32'd0,        32'd5,        0, 1, 33, 0);
    run_op("mod_a",    2'b00, 6'h0B, 32'd100,      32'd7,        32'd2,        0, 0, 33, 0);
    run_op("shl_big",  2'b00, 6'h07, 32'd1,        32'd32,       32'd0,        0, 0, 1,  0);
    run_op("shl_4",    2'b00, 6'h07, 32'd1,        32'd4,        32'd16,       0, 0, 1,  0);
    run_op("shr_31",   2'b00, 6'h08, 32'h80000000, 32'd31,       32'd1,        0, 0, 1,  0);
    run_op("x4",       2'b11, 6'h00, 32'd0,        32'd5,        32'd20,       0, 0, 1,  0);
    run_op("pass2",    2'b01, 6'h09, 32'd7,        32'h1234,     32'h1234,     0, 0, 1,  0);
    run_op("bne_eq",   2'b10, 6'h00, 32'd9,        32'd9,        32'd9,        0, 0, 1,  0);
    run_op("sub",      2'b00, 6'h02, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 0, 1,  0);
    run_op("and",      2'b00, 6'h03, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 0, 1,  0);
    run_op("or",       2'b00, 6'h04, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 0, 1,  0);
    run_op("xor_eq",   2'b00, 6'h05, 32'd5,        32'd5,        32'd0,        1, 0, 1,  0);
    run_op("not",      2'b00, 6'h06, 32'h0F0F0F0F, 32'd0,        32'hF0F0F0F0, 0, 0, 1,  0);
    run_op("bad_op",   2'b00, 6'h3F, 32'd1,        32'd2,        32'd0,        0, 0, 1,  0);
    run_op("mul_ff",   2'b00, 6'h09, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1, 0, 33, 0);
    run_op("mul_pert", 2'b00, 6'h09, 32'd123,      32'd456,      32'd56088,    0, 0, 33, 1);
    run_op("bne_ne",   2'b10, 6'h00, 32'd9,        32'd8,        32'd9,        1, 0, 1,  0);

    // Abort a divide with reset on its tenth cycle
    ALUOp     = 2'b00;
    operation = 6'h0A;
    data1     = 32'd100;
    data2     = 32'd7;
    start     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    check("abort_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_res", 64'(aluResult), 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    check("abort_dbz", 64'(divByZero), 64'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) dones++;
    end
    reset = 1'b0;
    run_op("post_rst", 2'b00, 6'h01, 32'd2, 32'd3, 32'd5, 0, 0, 1, 0);
    repeat (40) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("abort_nodone", 64'(dones), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
